syn_fetch_ctrl: RTL and testbench
=================================

Name: syn_fetch_ctrl

Overview:
Synapse-memory fetch controller that sits upstream of the core's time-multiplexed neuron controller.
- Buffers the presynaptic spike addresses for the current timestep.
- On each fetch request for one postsynaptic neuron, reads one weight per buffered spike from synchronous weight memory.
- Streams each weight as a data/valid pulse, then signals completion with a single done pulse.

Parameters:
DATA_WIDTH, 8, weight width
ADDR_WIDTH, 14, postsynaptic neuron index width
NEURON_COUNT, 10000, postsynaptic neurons
PRE_COUNT, 784, presynaptic inputs per neuron
PRE_ADDR_WIDTH, 10, presynaptic address width
FIFO_DEPTH, 64, spike buffer entries (power of 2)
CNT_WIDTH, 7, log2(FIFO_DEPTH)+1
WMEM_ADDR_WIDTH, 24, weight memory address width (ADDR_WIDTH+PRE_ADDR_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_in_spike_valid  in  1  input spike write strobe
i_in_spike_addr  in  PRE_ADDR_WIDTH  presynaptic index of spike
o_in_ready  out  1  buffer accepts write this cycle
i_buf_clear  in  1  empty buffer (end of timestep)
o_buf_count  out  CNT_WIDTH  buffered spike count
i_post_idx  in  ADDR_WIDTH  postsynaptic neuron index, sampled on fetch start; driven from the core's current neuron index
i_fetch_start  in  1  one-cycle fetch request
o_fetch_done  out  1  one-cycle completion pulse
o_weight_data  out  DATA_WIDTH  fetched weight
o_weight_valid  out  1  weight strobe
o_wmem_rd_en  out  1  weight memory read enable
o_wmem_addr  out  WMEM_ADDR_WIDTH  weight memory address
i_wmem_rdata  in  DATA_WIDTH  weight memory data, 1-cycle read latency
o_busy  out  1  fetch in progress
o_overflow  out  1  sticky: write dropped (full or addr>=PRE_COUNT)

Behaviour:
- Reset: all outputs 0, except o_in_ready=1. Buffer empty, state IDLE, o_overflow cleared. Reset mid-fetch aborts the fetch; no done pulse follows.
- o_in_ready = (state==IDLE) && (count<FIFO_DEPTH).
- Write accepted when valid && ready && addr<PRE_COUNT; the entry is appended at index count.
- valid && addr>=PRE_COUNT, or valid && count==FIFO_DEPTH in IDLE: write dropped, o_overflow set. A write attempted while busy is dropped silently, not flagged.
- i_buf_clear honoured only in IDLE: count<=0 next cycle. If clear and a write occur in the same cycle, clear wins.
- The buffer is never consumed by a fetch; the same spikes are reused for every neuron in the timestep.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_fetch_start -> latch i_post_idx, set rd_ptr<=0.
  - Next state ISSUE if count>0, else DONE.
- ISSUE:
  - Each cycle: o_wmem_rd_en=1, o_wmem_addr = post_idx*PRE_COUNT + buf[rd_ptr], computed at full width, no truncation.
  - rd_ptr increments each cycle; after count reads -> DRAIN.
- Pipeline: issue flag delayed 1 cycle captures i_wmem_rdata into o_weight_data, with o_weight_valid=1 for one cycle.
- DRAIN: wait until the final read's o_weight_valid has fired -> DONE.
- DONE: o_fetch_done=1 for exactly one cycle -> IDLE.
- Timing for start in cycle T with N spikes:
  - Reads in cycles T+1..T+N.
  - Valids in T+3..T+N+2.
  - Done in T+N+3.
  - For N=0: done in T+1, no valids.
- o_fetch_done never coincides with o_weight_valid.
- o_busy=1 whenever state != IDLE.
- i_fetch_start while busy is ignored.
- count==FIFO_DEPTH is legal; all entries are fetched.

Optional Feature:
SYN_ZERO_SKIP_EN
- Defined: a fetched weight equal to 0 produces no o_weight_valid pulse. Read timing and done timing are unchanged, so done still arrives at T+N+3.
- Undefined: every read produces a valid pulse, including zero weights.

Decomposition:
- Shared package snn_pkg holds DATA_WIDTH, ADDR_WIDTH, NEURON_COUNT, PRE_COUNT, PRE_ADDR_WIDTH and the FSM state encodings.
- One natural sub-module: spike_addr_buf, the register-array buffer with write port, clear, count and random read by rd_ptr.

Test Plan:
- Load spikes 3,7,783; start with post_idx=2, memory model returns addr[7:0]:
  - reads at addr 1571,1575,2351 in T+1..T+3;
  - valids with data 0x23,0x27,0x2F in T+3..T+5;
  - done at T+6.
- Empty buffer, start -> done at T+1, no valid, no rd_en.
- Write 64 spikes, then a 65th:
  - 65th dropped, o_overflow=1, count=64, o_in_ready=0;
  - a fetch produces 64 valids, then done.
- Write addr 784 -> dropped, o_overflow=1, count unchanged. Write during busy -> dropped, o_overflow stays 0.
- Start while busy, and i_buf_clear while busy -> both ignored; current fetch completes with the original count. Clear in IDLE -> count=0.
- Assert rst_n low in cycle T+2 of a 5-spike fetch -> outputs zero, no done; next fetch on an empty buffer -> done only.
- With SYN_ZERO_SKIP_EN, weights 0,5,0 -> a single valid with data 5; done still at T+6.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN core parameters, FSM state encodings and the weight-memory
// address helper used by the synapse fetch controller.
package snn_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int ADDR_WIDTH      = 14;
    localparam int NEURON_COUNT    = 10000;
    localparam int PRE_COUNT       = 784;
    localparam int PRE_ADDR_WIDTH  = 10;
    localparam int FIFO_DEPTH      = 64;
    localparam int CNT_WIDTH       = 7;
    localparam int PTR_WIDTH       = CNT_WIDTH - 1;
    localparam int WMEM_ADDR_WIDTH = ADDR_WIDTH + PRE_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Row-major weight layout: one row of PRE_COUNT weights per neuron.
    function automatic logic [WMEM_ADDR_WIDTH-1:0] wmem_index(
        input logic [ADDR_WIDTH-1:0]     post,
        input logic [PRE_ADDR_WIDTH-1:0] pre
    );
        return WMEM_ADDR_WIDTH'(post) * WMEM_ADDR_WIDTH'(PRE_COUNT)
             + WMEM_ADDR_WIDTH'(pre);
    endfunction

endpackage

// File: rtl/syn_fetch_ctrl_if.sv
// Spike-write, fetch-handshake and weight-memory signals of the synapse
// fetch controller; master is the core/memory side, slave is the controller.
interface syn_fetch_ctrl_if;
    import snn_pkg::*;

    logic                       spike_valid;
    logic [PRE_ADDR_WIDTH-1:0]  spike_addr;
    logic                       in_ready;
    logic                       buf_clear;
    logic [CNT_WIDTH-1:0]       buf_count;
    logic [ADDR_WIDTH-1:0]      post_idx;
    logic                       fetch_start;
    logic                       fetch_done;
    logic [DATA_WIDTH-1:0]      weight_data;
    logic                       weight_valid;
    logic                       wmem_rd_en;
    logic [WMEM_ADDR_WIDTH-1:0] wmem_addr;
    logic [DATA_WIDTH-1:0]      wmem_rdata;
    logic                       busy;
    logic                       overflow;

    modport master (
        output spike_valid, spike_addr, buf_clear, post_idx, fetch_start, wmem_rdata,
        input  in_ready, buf_count, fetch_done, weight_data, weight_valid,
               wmem_rd_en, wmem_addr, busy, overflow
    );

    modport slave (
        input  spike_valid, spike_addr, buf_clear, post_idx, fetch_start, wmem_rdata,
        output in_ready, buf_count, fetch_done, weight_data, weight_valid,
               wmem_rd_en, wmem_addr, busy, overflow
    );

endinterface

// File: rtl/spike_addr_buf.sv
// Register-array buffer of presynaptic spike addresses for one timestep:
// append-only write, clear, occupancy count and random read by pointer.
module spike_addr_buf
    import snn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [PRE_ADDR_WIDTH-1:0] wr_addr,
    input  logic                      clear,
    input  logic [PTR_WIDTH-1:0]      rd_ptr,
    output logic [PRE_ADDR_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]      count
);

    logic [PRE_ADDR_WIDTH-1:0] entries [FIFO_DEPTH];

    // Clear beats a same-cycle write; the caller never writes when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            entries[count[PTR_WIDTH-1:0]] <= wr_addr;
        end
    end

    assign rd_data = entries[rd_ptr];

endmodule

// File: rtl/syn_fetch_ctrl.sv
// Synapse fetch controller: replays the buffered spikes of a timestep as weight
// reads for one neuron. Build macro SYN_ZERO_SKIP_EN suppresses zero-weight pulses.
module syn_fetch_ctrl
    import snn_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    syn_fetch_ctrl_if.slave bus
);

    logic [1:0]                state;
    logic [CNT_WIDTH-1:0]      count;
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic [ADDR_WIDTH-1:0]     post_q;
    logic [PRE_ADDR_WIDTH-1:0] rd_data;
    logic                      idle;
    logic                      addr_ok;
    logic                      wr_en;
    logic                      clear_en;
    logic                      issue_d;

    assign idle         = (state == ST_IDLE);
    assign addr_ok      = (bus.spike_addr < PRE_ADDR_WIDTH'(PRE_COUNT));
    assign bus.in_ready = idle && (count < CNT_WIDTH'(FIFO_DEPTH));
    assign wr_en        = bus.spike_valid && bus.in_ready && addr_ok;
    assign clear_en     = idle && bus.buf_clear;

    spike_addr_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (bus.spike_addr),
        .clear   (clear_en),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rd_ptr <= '0;
            post_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.fetch_start) begin
                        post_q <= bus.post_idx;
                        rd_ptr <= '0;
                        state  <= (count != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if ({1'b0, rd_ptr} == count - 1'b1) begin
                        state <= ST_DRAIN;
                    end
                end
                // Leave once the last read's capture cycle has passed.
                ST_DRAIN: begin
                    if (!issue_d) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wmem_rd_en = (state == ST_ISSUE);
    assign bus.wmem_addr  = bus.wmem_rd_en ? wmem_index(post_q, rd_data) : '0;
    assign bus.fetch_done = (state == ST_DONE);
    assign bus.busy       = !idle;
    assign bus.buf_count  = count;

    // One cycle of memory latency, then one register stage to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_d          <= 1'b0;
            bus.weight_valid <= 1'b0;
            bus.weight_data  <= '0;
        end else begin
            issue_d <= bus.wmem_rd_en;
`ifdef SYN_ZERO_SKIP_EN
            bus.weight_valid <= issue_d && (bus.wmem_rdata != '0);
`else
            bus.weight_valid <= issue_d;
`endif
            if (issue_d) begin
                bus.weight_data <= bus.wmem_rdata;
            end
        end
    end

    // Busy-time writes are dropped without flagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow <= 1'b0;
        end else if (idle && bus.spike_valid &&
                     (!addr_ok || count == CNT_WIDTH'(FIFO_DEPTH))) begin
            bus.overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_syn_fetch_ctrl.sv
// Self-checking bench for syn_fetch_ctrl: directed steps plus randomized spike
// sets, checked cycle by cycle against a queue-based reference model.
module tb_syn_fetch_ctrl;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    syn_fetch_ctrl_if bus ();

    syn_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned mem_key;
    int          checks = 0;
    int          errors = 0;
    int          q[$];
    bit          ovf_m;

    // Weight memory contents: addr[7:0] when key is 0, else a keyed hash.
    function automatic logic [7:0] mem_val(input logic [23:0] a);
        logic [31:0] h;
        if (mem_key == 0) return a[7:0];
        h = {8'd0, a} * mem_key;
        return h[15:8];
    endfunction

    always @(posedge clk) begin
        if (bus.wmem_rd_en) bus.wmem_rdata <= mem_val(bus.wmem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.fetch_done, 0);
        chk({tag, "_valid"}, bus.weight_valid, 0);
        chk({tag, "_data"}, bus.weight_data, 0);
        chk({tag, "_rd_en"}, bus.wmem_rd_en, 0);
        chk({tag, "_addr"}, bus.wmem_addr, 0);
        chk({tag, "_count"}, bus.buf_count, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
    endtask

    // Called with the DUT idle, just after a falling edge.
    task automatic write_spike(input int a);
        bus.spike_valid = 1'b1;
        bus.spike_addr  = a[9:0];
        @(negedge clk);
        bus.spike_valid = 1'b0;
        if (a >= PRE_COUNT || q.size() == FIFO_DEPTH) ovf_m = 1'b1;
        else q.push_back(a);
        chk("wr_count", bus.buf_count, q.size());
        chk("wr_ovf", bus.overflow, ovf_m);
        chk("wr_in_ready", bus.in_ready, (q.size() < FIFO_DEPTH) ? 1 : 0);
    endtask

    // Clear in IDLE with a competing valid write: the clear must win.
    task automatic clear_buf();
        bus.buf_clear   = 1'b1;
        bus.spike_valid = 1'b1;
        bus.spike_addr  = 10'd12;
        @(negedge clk);
        bus.buf_clear   = 1'b0;
        bus.spike_valid = 1'b0;
        if (q.size() == FIFO_DEPTH) ovf_m = 1'b1;
        q.delete();
        chk("clear_count", bus.buf_count, 0);
    endtask

    // Start at cycle T, check every cycle T+1..end against the model timeline.
    task automatic do_fetch(input int post, input bit inject);
        int n    = q.size();
        int last = (n == 0) ? 1 : n + 3;
        bus.post_idx    = post[13:0];
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        bus.post_idx    = 14'($urandom_range(0, NEURON_COUNT - 1));
        for (int k = 1; k <= last; k++) begin
            bit          exp_rd = (k <= n);
            int          exp_addr = exp_rd ? post * PRE_COUNT + q[k-1] : 0;
            int          vi = k - 3;
            bit          vok = (vi >= 0) && (vi < n);
            logic [7:0]  d = 8'd0;
            if (vok) d = mem_val(24'(post * PRE_COUNT + q[vi]));
`ifdef SYN_ZERO_SKIP_EN
            if (d == 8'd0) vok = 1'b0;
`endif
            chk("f_rd_en", bus.wmem_rd_en, exp_rd);
            chk("f_addr", bus.wmem_addr, exp_addr);
            chk("f_valid", bus.weight_valid, vok);
            chk("f_done", bus.fetch_done, (k == last) ? 1 : 0);
            chk("f_busy", bus.busy, 1);
            if (vok) chk("f_data", bus.weight_data, d);
            bus.fetch_start = inject && (k == 2);
            bus.buf_clear   = inject && (k == 2);
            bus.spike_valid = inject && (k == 2);
            bus.spike_addr  = 10'd5;
            if (k < last) @(negedge clk);
        end
        bus.fetch_start = 1'b0;
        bus.buf_clear   = 1'b0;
        bus.spike_valid = 1'b0;
        @(negedge clk);
        chk("f_post_done", bus.fetch_done, 0);
        chk("f_post_busy", bus.busy, 0);
        chk("f_post_count", bus.buf_count, n);
        chk("f_post_ovf", bus.overflow, ovf_m);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.spike_valid = 1'b0;
        bus.spike_addr  = '0;
        bus.buf_clear   = 1'b0;
        bus.post_idx    = '0;
        bus.fetch_start = 1'b0;
        mem_key         = 0;
        ovf_m           = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");

        // Spikes 3,7,783 for neuron 2, with start/clear/write injected mid-fetch.
        write_spike(3);
        write_spike(7);
        write_spike(783);
        do_fetch(2, 1'b1);

        clear_buf();
        do_fetch(9999, 1'b0);

        // Weights 0,5,0 under the addr[7:0] memory.
        write_spike(0);
        write_spike(5);
        write_spike(256);
        do_fetch(0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 12);
            clear_buf();
            for (int i = 0; i < n; i++) begin
                int a = ($urandom_range(0, 7) == 0) ? $urandom_range(PRE_COUNT, 1023)
                                                    : $urandom_range(0, PRE_COUNT - 1);
                write_spike(a);
            end
            mem_key = $urandom | 1;
            do_fetch($urandom_range(0, NEURON_COUNT - 1), 1'b0);
        end

        // Out-of-range address, then a full buffer with one extra write.
        clear_buf();
        write_spike(1);
        write_spike(PRE_COUNT);
        chk("oor_ovf", bus.overflow, 1);
        clear_buf();
        mem_key = 0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) write_spike($urandom_range(0, PRE_COUNT - 1));
        chk("full_count", bus.buf_count, FIFO_DEPTH);
        chk("full_ready", bus.in_ready, 0);
        do_fetch(123, 1'b0);

        // Reset asserted in cycle T+2 of a 5-spike fetch.
        clear_buf();
        for (int i = 0; i < 5; i++) write_spike(100 + i);
        bus.post_idx    = 14'd7;
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_en", bus.wmem_rd_en, 0);
        chk("abort_busy", bus.busy, 0);
        q.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_zero("abort");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus.fetch_done, 0);
        end
        do_fetch(42, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
